// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word over a
// valid/ready handshake and shifts it out one bit per enabled clock.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  logic             last_s;
  logic             accept_s;
  logic             out_bit_s;
  logic [WIDTH-1:0] shifted_s;

  // Handshake, last-bit detect and output decode of the registered state.
  always_comb begin
    last_s     = 1'b0;
    load_ready = 1'b0;
    accept_s   = 1'b0;
    out_bit_s  = 1'b0;
    shifted_s  = '0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;

    last_s = (state_r == SHIFT) && en && (cnt_r == LAST_IDX);

    // A new word is only taken in IDLE or on the edge that consumes the last bit.
    if (reset) begin
      load_ready = 1'b0;
    end else if (state_r == IDLE) begin
      load_ready = 1'b1;
    end else begin
      load_ready = last_s;
    end
    accept_s = load_valid && load_ready;

    if (MSB_FIRST) begin
      out_bit_s = shreg_r[WIDTH-1];
      shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
    end else begin
      out_bit_s = shreg_r[0];
      shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
    end

    if (!reset && (state_r == SHIFT)) begin
      sout       = out_bit_s;
      sout_valid = 1'b1;
      busy       = 1'b1;
    end else begin
      sout       = 1'b0;
      sout_valid = 1'b0;
      busy       = 1'b0;
    end
  end

  assign done = done_r;

  // State, shift register, bit counter and end-of-word pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      shreg_r <= '0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        shreg_r <= din;
        cnt_r   <= '0;
        state_r <= SHIFT;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          SHIFT: begin
            if (en) begin
              shreg_r <= shifted_s;
              if (last_s) begin
                cnt_r   <= '0;
                state_r <= IDLE;
              end else begin
                cnt_r   <= cnt_r + CW'(1);
                state_r <= SHIFT;
              end
            end else begin
              state_r <= SHIFT;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance, hand-computed bit streams checked with immediate assertions.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] din_a, din_b;
  logic       lv_a, lv_b;
  logic       ready_a, sout_a, valid_a, busy_a, done_a;
  logic       ready_b, sout_b, valid_b, busy_b, done_b;

  logic       sel;
  logic       o_ready, o_sout, o_valid, o_busy, o_done;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .din(din_a), .load_valid(lv_a),
    .load_ready(ready_a), .sout(sout_a), .sout_valid(valid_a),
    .busy(busy_a), .done(done_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .din(din_b), .load_valid(lv_b),
    .load_ready(ready_b), .sout(sout_b), .sout_valid(valid_b),
    .busy(busy_b), .done(done_b)
  );

  assign o_ready = sel ? ready_b : ready_a;
  assign o_sout  = sel ? sout_b  : sout_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_load(input logic [7:0] w, input logic v);
    if (sel) begin
      din_b = w;
      lv_b  = v;
    end else begin
      din_a = w;
      lv_a  = v;
    end
  endtask

  // seq[7] is the first bit expected on sout; en must be 1 throughout.
  task automatic stream(input logic [7:0] seq, input bit done_first);
    for (int i = 0; i < 8; i++) begin
      chk("sout_bit", o_sout, seq[7-i]);
      chk("sout_valid", o_valid, 1'b1);
      chk("busy", o_busy, 1'b1);
      chk("done_in_word", o_done, (i == 0 && done_first) ? 1'b1 : 1'b0);
      chk("ready_in_word", o_ready, (i == 7) ? 1'b1 : 1'b0);
      tick();
    end
  endtask

  task automatic finish_word();
    chk("done_pulse", o_done, 1'b1);
    chk("busy_after", o_busy, 1'b0);
    chk("valid_after", o_valid, 1'b0);
    chk("sout_idle", o_sout, 1'b0);
    chk("ready_after", o_ready, 1'b1);
    tick();
    chk("done_one_cycle", o_done, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    sel   = 1'b0;
    reset = 1'b1;
    en    = 1'b0;
    din_a = 8'hFF;
    lv_a  = 1'b1;
    din_b = 8'h00;
    lv_b  = 1'b0;

    // Reset held with load_valid asserted: nothing loads, outputs quiet.
    tick();
    tick();
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_done", o_done, 1'b0);
    reset = 1'b0;
    drive_load(8'h00, 1'b0);
    tick();
    chk("idle_ready", o_ready, 1'b1);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_valid", o_valid, 1'b0);
    chk("idle_sout", o_sout, 1'b0);
    chk("idle_done", o_done, 1'b0);

    // 0xA5 MSB first, en constant.
    en = 1'b1;
    drive_load(8'hA5, 1'b1);
    #1;
    chk("load_ready_idle", o_ready, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    stream(8'hA5, 1'b0);
    finish_word();

    // 0xF0 with 3-cycle stalls after bits 2 and 5.
    w = 8'hF0;
    drive_load(w, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("stall_bit", o_sout, w[7-i]);
      chk("stall_valid", o_valid, 1'b1);
      chk("stall_done", o_done, 1'b0);
      tick();
      if (i == 1 || i == 4) begin
        en = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
          chk("stall_hold", o_sout, w[6-i]);
          chk("stall_hold_valid", o_valid, 1'b1);
          chk("stall_ready", o_ready, 1'b0);
          tick();
        end
        en = 1'b1;
      end
    end
    finish_word();

    // Back-to-back 0xC3 then 0x3C with load_valid held.
    drive_load(8'hC3, 1'b1);
    tick();
    drive_load(8'h3C, 1'b1);
    stream(8'hC3, 1'b0);
    drive_load(8'h00, 1'b0);
    stream(8'h3C, 1'b1);
    finish_word();

    // 0xFF offered while 0x00 is mid-word; it must wait for the last-bit edge.
    drive_load(8'h00, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) drive_load(8'hFF, 1'b1);
      #1;
      chk("busy_sout_zero", o_sout, 1'b0);
      chk("busy_ready", o_ready, (i == 7) ? 1'b1 : 1'b0);
      tick();
    end
    drive_load(8'h00, 1'b0);
    stream(8'hFF, 1'b1);
    finish_word();

    // Reset after bit 3 of 0x5A, with 0x81 already offered during reset.
    w = 8'h5A;
    drive_load(w, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pre_rst_bit", o_sout, w[7-i]);
      tick();
    end
    reset = 1'b1;
    drive_load(8'h81, 1'b1);
    #1;
    chk("midrst_ready", o_ready, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_sout", o_sout, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst_valid", o_valid, 1'b0);
    chk("postrst_busy", o_busy, 1'b0);
    chk("postrst_done", o_done, 1'b0);
    chk("postrst_ready", o_ready, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    stream(8'h81, 1'b0);
    finish_word();

    // LSB-first instance: 0xA5 and 0x01.
    sel = 1'b1;
    #1;
    chk("lsb_idle_ready", o_ready, 1'b1);
    drive_load(8'hA5, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    stream(8'hA5, 1'b0);
    finish_word();
    drive_load(8'h01, 1'b1);
    tick();
    drive_load(8'h00, 1'b0);
    stream(8'h80, 1'b0);
    finish_word();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
